instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 129 ++++++++++++
 tb/tb_instr_encoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns a field bundle into a 32-bit instruction word
// and presents it with its byte address through a one-deep valid/ready output stage.
module instr_encoder #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        fmt,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [31:0]       imm,
   input  logic              base_load,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W+1:0] out_addr,
   output logic              err,
   output logic [15:0]       count
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] word_reg, word_next;
   logic [31:0]       instr_reg;
   logic [ADDR_W+1:0] addr_reg;
   logic              err_reg;
   logic [15:0]       count_reg;
   logic [31:0]       enc;
   logic              illegal;
   logic              accept;
   logic              xfer;

   always_comb begin
      enc     = '0;
      illegal = 1'b0;
      case (fmt)
         4'd0: enc = {funct7, rs2, rs1, funct3, rd, OP_R};
         4'd1: begin
            // Shift-immediate forms carry funct7 above a 5-bit shift amount.
            if (funct3 == 3'b001 || funct3 == 3'b101)
               enc = {funct7, imm[4:0], rs1, funct3, rd, OP_I};
            else
               enc = {imm[11:0], rs1, funct3, rd, OP_I};
         end
         4'd2: enc = {imm[11:0], rs1, funct3, rd, OP_LOAD};
         4'd3: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
         4'd4: begin
            enc     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
            illegal = imm[0];
         end
         4'd5: begin
            enc     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            illegal = imm[0];
         end
         4'd6: enc = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
         4'd7: enc = {imm[31:12], rd, OP_LUI};
         4'd8: enc = {imm[31:12], rd, OP_AUIPC};
         default: illegal = 1'b1;
      endcase
   end

   assign out_valid = (state_reg == FULL);
   assign in_ready  = rst && (state_reg == EMPTY || out_ready);
   assign accept    = in_valid && in_ready;
   assign xfer      = out_valid && out_ready;

   // word_next is both the post-cycle write address and the address of any word accepted now.
   always_comb begin
      state_next = state_reg;
      word_next  = word_reg;
      if (xfer) begin
         state_next = EMPTY;
         word_next  = base_load ? base_addr : word_reg + 1'b1;
      end else if (state_reg == EMPTY && base_load) begin
         word_next = base_addr;
      end
      if (accept && !illegal)
         state_next = FULL;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         state_reg <= EMPTY;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         word_reg  <= '0;
         instr_reg <= '0;
         addr_reg  <= '0;
         err_reg   <= 1'b0;
         count_reg <= '0;
      end else begin
         word_reg <= word_next;
         err_reg  <= accept && illegal;
         if (accept && !illegal) begin
            instr_reg <= enc;
            addr_reg  <= {word_next, 2'b00};
         end
         if (xfer && count_reg != 16'hFFFF)
            count_reg <= count_reg + 1'b1;
      end
   end

   assign out_instr = instr_reg;
   assign out_addr  = addr_reg;
   assign err       = err_reg;
   assign count     = count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table vectors, directed handshake/address sequences and
// randomized traffic against a field-level reference model (two DUT widths share stimulus).
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [3:0]  fmt = '0;
   logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
   logic [2:0]  funct3 = '0;
   logic [6:0]  funct7 = '0;
   logic [31:0] imm = '0;
   logic        base_load = 1'b0;
   logic [9:0]  base_addr = '0;
   logic [1:0]  base_addr2;

   logic        in_ready, out_valid, err;
   logic [31:0] out_instr;
   logic [11:0] out_addr;
   logic [15:0] count;
   logic        in_ready2, out_valid2, err2;
   logic [31:0] out_instr2;
   logic [3:0]  out_addr2;
   logic [15:0] count2;

   assign base_addr2 = base_addr[1:0];

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(10)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
      .imm(imm), .base_load(base_load), .base_addr(base_addr),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_addr(out_addr), .err(err), .count(count)
   );

   instr_encoder #(.ADDR_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
      .imm(imm), .base_load(base_load), .base_addr(base_addr2),
      .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
      .out_addr(out_addr2), .err(err2), .count(count2)
   );

   typedef struct {
      logic [3:0]  fmt;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] instr;
      logic        bad;
   } vec_t;

   vec_t vecs[12];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: held word, its word address, next write address, counters.
   bit          m_full = 0;
   logic [31:0] m_instr = '0;
   int unsigned m_addr = 0;
   int unsigned m_word = 0;
   int unsigned m_count = 0;
   bit          m_err = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit ref_legal(logic [3:0] f, logic [31:0] im);
      return (f <= 4'd8) && !((f == 4'd4 || f == 4'd5) && im[0]);
   endfunction

   function automatic logic [31:0] ref_encode(logic [3:0] f, logic [4:0] d, logic [4:0] s1,
                                              logic [4:0] s2, logic [2:0] f3, logic [6:0] f7,
                                              logic [31:0] im);
      logic [31:0] mid;
      mid = (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7);
      case (f)
         4'd0: return (32'(f7) << 25) | (32'(s2) << 20) | mid | 32'h33;
         4'd1: begin
            if (f3 == 3'd1 || f3 == 3'd5)
               return (32'(f7) << 25) | ((im & 32'd31) << 20) | mid | 32'h13;
            return (im << 20) | mid | 32'h13;
         end
         4'd2: return (im << 20) | mid | 32'h03;
         4'd3: return (((im >> 5) & 32'd127) << 25) | (32'(s2) << 20) | (32'(s1) << 15)
                      | (32'(f3) << 12) | ((im & 32'd31) << 7) | 32'h23;
         4'd4: return (((im >> 12) & 32'd1) << 31) | (((im >> 5) & 32'd63) << 25)
                      | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12)
                      | (((im >> 1) & 32'd15) << 8) | (((im >> 11) & 32'd1) << 7) | 32'h63;
         4'd5: return (((im >> 20) & 32'd1) << 31) | (((im >> 1) & 32'd1023) << 21)
                      | (((im >> 11) & 32'd1) << 20) | (((im >> 12) & 32'd255) << 12)
                      | (32'(d) << 7) | 32'h6F;
         4'd6: return (im << 20) | (32'(s1) << 15) | (32'(d) << 7) | 32'h67;
         4'd7: return (im & 32'hFFFFF000) | (32'(d) << 7) | 32'h37;
         4'd8: return (im & 32'hFFFFF000) | (32'(d) << 7) | 32'h17;
         default: return 32'h0;
      endcase
   endfunction

   task automatic set_fields(vec_t v);
      fmt = v.fmt; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
      funct3 = v.f3; funct7 = v.f7; imm = v.imm;
   endtask

   // One clock: check in_ready, advance the model, then compare registered outputs.
   task automatic tick();
      bit          exp_rdy, acc, xfer, legal;
      int unsigned nw;
      logic [31:0] e;
      #1;
      exp_rdy = rst && (!m_full || out_ready);
      check("in_ready", in_ready, exp_rdy);
      check("in_ready_w2", in_ready2, exp_rdy);
      acc   = in_valid && exp_rdy;
      legal = ref_legal(fmt, imm);
      e     = ref_encode(fmt, rd, rs1, rs2, funct3, funct7, imm);
      xfer  = rst && m_full && out_ready;
      if (!rst) begin
         m_full = 0; m_instr = '0; m_addr = 0; m_word = 0; m_count = 0; m_err = 0;
      end else begin
         if (xfer)
            nw = base_load ? 32'(base_addr) : (m_word + 1) % 1024;
         else if (!m_full && base_load)
            nw = 32'(base_addr);
         else
            nw = m_word;
         m_err = acc && !legal;
         if (xfer && m_count < 65535) m_count++;
         if (acc && legal) begin
            m_full = 1; m_instr = e; m_addr = nw;
         end else if (xfer) begin
            m_full = 0;
         end
         m_word = nw;
      end
      @(posedge clk);
      #1;
      check("out_valid", out_valid, m_full);
      check("out_valid_w2", out_valid2, m_full);
      check("err", err, m_err);
      check("err_w2", err2, m_err);
      check("count", count, m_count);
      check("count_w2", count2, m_count);
      if (m_full) begin
         check("out_instr", out_instr, m_instr);
         check("out_instr_w2", out_instr2, m_instr);
         check("out_addr", out_addr, 64'(m_addr * 4));
         check("out_addr_w2", out_addr2, 64'((m_addr % 4) * 4));
      end
      if (acc && legal)
         $display("txn fmt=%0d instr=%08h addr=%03h count=%0d", fmt, m_instr, m_addr * 4, m_count);
      else if (acc)
         $display("txn fmt=%0d imm=%08h rejected", fmt, imm);
   endtask

   initial begin
      logic [31:0] held;
      logic [15:0] cnt0;
      logic [11:0] a0, ea;
      logic [3:0]  exp_wrap[5];

      vecs[0]  = '{4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,          32'h00500093, 1'b0};
      vecs[1]  = '{4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,          32'h0020A423, 1'b0};
      vecs[2]  = '{4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8,          32'h008000EF, 1'b0};
      vecs[3]  = '{4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000,   32'h123452B7, 1'b0};
      vecs[4]  = '{4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,          32'h002081B3, 1'b0};
      vecs[5]  = '{4'd1, 5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 32'd3,          32'h40335293, 1'b0};
      vecs[6]  = '{4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd8,          32'h00208463, 1'b0};
      vecs[7]  = '{4'd6, 5'd1, 5'd2, 5'd0, 3'd7, 7'h00, 32'd4,          32'h004100E7, 1'b0};
      vecs[8]  = '{4'd8, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'hABCDE123,   32'hABCDE197, 1'b0};
      vecs[9]  = '{4'd2, 5'd4, 5'd2, 5'd0, 3'd2, 7'h00, 32'hFFFFFFFC,   32'hFFC12203, 1'b0};
      vecs[10] = '{4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3,          32'h00000000, 1'b1};
      vecs[11] = '{4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'd4,         32'h00000000, 1'b1};
      exp_wrap = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h0};

      // Reset with traffic offered: nothing may be accepted.
      rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; set_fields(vecs[0]);
      tick();
      tick();
      check("rst_instr", out_instr, 32'h0);
      check("rst_addr", out_addr, 12'h0);
      rst = 1'b1; in_valid = 1'b0;

      foreach (vecs[i]) begin
         set_fields(vecs[i]); in_valid = 1'b1; out_ready = 1'b1;
         tick();
         if (vecs[i].bad) begin
            check("vec_err", err, 1'b1);
            check("vec_rej_valid", out_valid, 1'b0);
         end else begin
            check("vec_valid", out_valid, 1'b1);
            check("vec_instr", out_instr, vecs[i].instr);
         end
         in_valid = 1'b0;
         tick();
      end

      // Address wrap on the narrow instance.
      rst = 1'b0; tick(); rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         set_fields(vecs[k % 4]); in_valid = 1'b1; out_ready = 1'b1;
         tick();
         check("wrap_addr", out_addr2, exp_wrap[k]);
      end
      in_valid = 1'b0;
      tick();
      check("wrap_count", count, 16'd5);

      // Back-pressure: held word must not move, then drain back-to-back.
      set_fields(vecs[0]); in_valid = 1'b1; out_ready = 1'b0;
      tick();
      held = out_instr; cnt0 = count;
      for (int k = 0; k < 3; k++) begin
         set_fields(vecs[k + 1]); in_valid = 1'b1; out_ready = 1'b0;
         #1 check("stall_ready", in_ready, 1'b0);
         tick();
         check("stall_instr", out_instr, held);
         check("stall_count", count, cnt0);
      end
      a0 = out_addr;
      for (int k = 0; k < 3; k++) begin
         set_fields(vecs[k + 4]); in_valid = 1'b1; out_ready = 1'b1;
         tick();
         ea = a0 + 12'(4 * (k + 1));
         check("b2b_valid", out_valid, 1'b1);
         check("b2b_addr", out_addr, ea);
         check("b2b_instr", out_instr, vecs[k + 4].instr);
      end
      in_valid = 1'b0;
      tick();

      // Base preset with simultaneous accept, then preset during a transfer, then reset mid-FULL.
      set_fields(vecs[3]); base_load = 1'b1; base_addr = 10'h010; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      check("base_addr", out_addr, 12'h040);
      base_addr = 10'h020; out_ready = 1'b1;
      tick();
      check("base_xfer_addr", out_addr, 12'h080);
      base_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      check("rst_full_valid", out_valid, 1'b0);
      check("rst_full_count", count, 16'd0);
      rst = 1'b1;

      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         rst       = ($urandom_range(0, 99) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         base_load = ($urandom_range(0, 15) == 0);
         base_addr = 10'($urandom);
         fmt       = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
         rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
         funct3 = 3'($urandom); funct7 = 7'($urandom); imm = $urandom;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
